// File: rtl/seg7_scan_driver_if.sv
// Load channel for the 7-segment scan driver: one 16-bit word per valid/ready transfer.
interface seg7_scan_driver_if;
  logic        Load_valid;
  logic        Load_ready;
  logic [15:0] Load_data;

  modport master (output Load_valid, output Load_data, input Load_ready);
  modport slave  (input Load_valid, input Load_data, output Load_ready);
endinterface

// File: rtl/seg7_scan_driver.sv
// Four-digit multiplexed 7-segment driver with a double-buffered load path.
// New words are staged in a pending register and only reach the display at a frame boundary.
module seg7_scan_driver #(
  parameter int DIV = 50000
) (
  input  logic                Clock,
  input  logic                Reset_n,
  seg7_scan_driver_if.slave   load,
  input  logic                Blank_lz,
  output logic [3:0]          Digit_sel,
  output logic [6:0]          Seg_out,
  output logic                Frame_done
);

  localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = 7'h3F;
      4'h1:    seg = 7'h06;
      4'h2:    seg = 7'h5B;
      4'h3:    seg = 7'h4F;
      4'h4:    seg = 7'h66;
      4'h5:    seg = 7'h6D;
      4'h6:    seg = 7'h7D;
      4'h7:    seg = 7'h07;
      4'h8:    seg = 7'h7F;
      4'h9:    seg = 7'h6F;
      4'hA:    seg = 7'h77;
      4'hB:    seg = 7'h7C;
      4'hC:    seg = 7'h39;
      4'hD:    seg = 7'h5E;
      4'hE:    seg = 7'h79;
      4'hF:    seg = 7'h71;
      default: seg = 7'h00;
    endcase
    return seg;
  endfunction

  logic [CW-1:0] count_r, count_nxt_s;
  logic [3:0]    digit_sel_r, digit_sel_nxt_s;
  logic [15:0]   pending_r, pending_nxt_s;
  logic [15:0]   active_r, active_nxt_s;
  logic          full_r, full_nxt_s;
  logic          frame_done_r;
  logic          tick_s, boundary_s, xfer_s;
  logic [3:0]    nibble_s;
  logic          blank_s;

  // Next-state logic: prescaler, digit rotation and the pending/active hand-over.
  always_comb begin
    count_nxt_s     = count_r;
    digit_sel_nxt_s = digit_sel_r;
    pending_nxt_s   = pending_r;
    active_nxt_s    = active_r;
    full_nxt_s      = full_r;

    tick_s = (count_r == LAST);
    if (tick_s) begin
      count_nxt_s = {CW{1'b0}};
    end else begin
      count_nxt_s = count_r + {{(CW-1){1'b0}}, 1'b1};
    end

    // A corrupted select recovers to digit 0 without waiting for a tick.
    if (!$onehot(digit_sel_r)) begin
      digit_sel_nxt_s = 4'b0001;
    end else if (tick_s) begin
      digit_sel_nxt_s = {digit_sel_r[2:0], digit_sel_r[3]};
    end else begin
      digit_sel_nxt_s = digit_sel_r;
    end

    boundary_s = tick_s && (digit_sel_r == 4'b1000);
    xfer_s     = load.Load_valid && !full_r;

    // Transfers only happen while empty, so they never collide with a promotion.
    if (boundary_s && full_r) begin
      active_nxt_s = pending_r;
      full_nxt_s   = 1'b0;
    end else if (xfer_s) begin
      pending_nxt_s = load.Load_data;
      full_nxt_s    = 1'b1;
    end else begin
      full_nxt_s = full_r;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      count_r      <= {CW{1'b0}};
      digit_sel_r  <= 4'b0001;
      pending_r    <= 16'h0000;
      active_r     <= 16'h0000;
      full_r       <= 1'b0;
      frame_done_r <= 1'b0;
    end else begin
      count_r      <= count_nxt_s;
      digit_sel_r  <= digit_sel_nxt_s;
      pending_r    <= pending_nxt_s;
      active_r     <= active_nxt_s;
      full_r       <= full_nxt_s;
      frame_done_r <= boundary_s;
    end
  end

  // Segment decode of the selected nibble with leading-zero blanking.
  always_comb begin
    nibble_s = active_r[3:0];
    blank_s  = 1'b0;
    case (digit_sel_r)
      4'b0010: begin
        nibble_s = active_r[7:4];
        blank_s  = (active_r[15:4] == 12'h000);
      end
      4'b0100: begin
        nibble_s = active_r[11:8];
        blank_s  = (active_r[15:8] == 8'h00);
      end
      4'b1000: begin
        nibble_s = active_r[15:12];
        blank_s  = (active_r[15:12] == 4'h0);
      end
      default: begin
        nibble_s = active_r[3:0];
        blank_s  = 1'b0;
      end
    endcase
    if (Blank_lz && blank_s) begin
      Seg_out = 7'h00;
    end else begin
      Seg_out = hex_to_seg(nibble_s);
    end
  end

  assign Digit_sel       = digit_sel_r;
  assign Frame_done      = frame_done_r;
  assign load.Load_ready = ~full_r;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with DIV = 4 (one digit slot = 4 clocks, one frame = 16).
module tb_seg7_scan_driver;

  logic       Clock = 1'b0;
  logic       Reset_n;
  logic       Blank_lz;
  logic [3:0] Digit_sel;
  logic [6:0] Seg_out;
  logic       Frame_done;
  int         t = 0;
  int         total = 0;
  int         passed = 0;

  seg7_scan_driver_if ld_if ();

  seg7_scan_driver #(.DIV(4)) dut (
    .Clock      (Clock),
    .Reset_n    (Reset_n),
    .load       (ld_if.slave),
    .Blank_lz   (Blank_lz),
    .Digit_sel  (Digit_sel),
    .Seg_out    (Seg_out),
    .Frame_done (Frame_done)
  );

  always #5 Clock = ~Clock;

  task automatic cyc(input int n);
    repeat (n) @(negedge Clock);
    t = t + n;
  endtask

  task automatic go(input int target);
    cyc(target - t);
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  initial begin
    Reset_n          = 1'b0;
    Blank_lz         = 1'b0;
    ld_if.Load_valid = 1'b0;
    ld_if.Load_data  = 16'h0000;
    cyc(3);
    check("rst_sel",   {12'h000, Digit_sel}, 16'h0001);
    check("rst_seg",   {9'h000, Seg_out},    16'h003F);
    check("rst_ready", {15'h0000, ld_if.Load_ready}, 16'h0001);
    check("rst_fd",    {15'h0000, Frame_done}, 16'h0000);

    // idle scan after release; t counts rising edges since release
    Reset_n = 1'b1;
    t = 0;
    go(3);  check("idle_sel3",  {12'h000, Digit_sel}, 16'h0001);
    go(4);  check("idle_sel4",  {12'h000, Digit_sel}, 16'h0002);
    go(8);  check("idle_sel8",  {12'h000, Digit_sel}, 16'h0004);
    go(12); check("idle_sel12", {12'h000, Digit_sel}, 16'h0008);
    go(15); check("idle_fd15",  {15'h0000, Frame_done}, 16'h0000);
    go(16); check("idle_sel16", {12'h000, Digit_sel}, 16'h0001);
            check("idle_fd16",  {15'h0000, Frame_done}, 16'h0001);
    go(17); check("idle_fd17",  {15'h0000, Frame_done}, 16'h0000);

    // load 0x12AF, displayed from the boundary at edge 32
    ld_if.Load_valid = 1'b1;
    ld_if.Load_data  = 16'h12AF;
    go(18);
    ld_if.Load_valid = 1'b0;
    check("l1_ready0", {15'h0000, ld_if.Load_ready}, 16'h0000);
    check("l1_old",    {9'h000, Seg_out}, 16'h003F);
    go(31); check("l1_ready_bnd", {15'h0000, ld_if.Load_ready}, 16'h0000);
    go(32); check("l1_ready1", {15'h0000, ld_if.Load_ready}, 16'h0001);
            check("l1_d0", {9'h000, Seg_out}, 16'h0071);
    go(36); check("l1_d1", {9'h000, Seg_out}, 16'h0077);
    go(40); check("l1_d2", {9'h000, Seg_out}, 16'h005B);
    go(44); check("l1_d3", {9'h000, Seg_out}, 16'h0006);

    // 0x1111 then 0x2222 held while full
    ld_if.Load_valid = 1'b1;
    ld_if.Load_data  = 16'h1111;
    go(45);
    check("l2_ready0", {15'h0000, ld_if.Load_ready}, 16'h0000);
    ld_if.Load_data = 16'h2222;
    go(47); check("l2_hold", {15'h0000, ld_if.Load_ready}, 16'h0000);
    go(48); check("l2_ready1", {15'h0000, ld_if.Load_ready}, 16'h0001);
            check("l2_d0", {9'h000, Seg_out}, 16'h0006);
    go(49);
    ld_if.Load_valid = 1'b0;
    check("l3_ready0", {15'h0000, ld_if.Load_ready}, 16'h0000);
    go(52); check("l2_d1", {9'h000, Seg_out}, 16'h0006);
    go(64); check("l3_d0", {9'h000, Seg_out}, 16'h005B);
            check("l3_ready1", {15'h0000, ld_if.Load_ready}, 16'h0001);

    // leading-zero blanking on 0x0050
    ld_if.Load_valid = 1'b1;
    ld_if.Load_data  = 16'h0050;
    go(65);
    ld_if.Load_valid = 1'b0;
    Blank_lz = 1'b1;
    go(80); check("bl_d0", {9'h000, Seg_out}, 16'h003F);
    go(84); check("bl_d1", {9'h000, Seg_out}, 16'h006D);
    go(88); check("bl_d2", {9'h000, Seg_out}, 16'h0000);
    go(92); check("bl_d3", {9'h000, Seg_out}, 16'h0000);
    Blank_lz = 1'b0;
    #1 check("nobl_d3", {9'h000, Seg_out}, 16'h003F);
    go(104); check("nobl_d2", {9'h000, Seg_out}, 16'h003F);
    Blank_lz = 1'b1;
    #1 check("rebl_d2", {9'h000, Seg_out}, 16'h0000);
    Blank_lz = 1'b0;

    // transfer coinciding with the boundary at edge 112
    go(111);
    ld_if.Load_valid = 1'b1;
    ld_if.Load_data  = 16'h9999;
    go(112);
    ld_if.Load_valid = 1'b0;
    check("bnd_fd",    {15'h0000, Frame_done}, 16'h0001);
    check("bnd_ready", {15'h0000, ld_if.Load_ready}, 16'h0000);
    check("bnd_keep0", {9'h000, Seg_out}, 16'h003F);
    go(116); check("bnd_keep1", {9'h000, Seg_out}, 16'h006D);
    go(128); check("bnd_new0",  {9'h000, Seg_out}, 16'h006F);

    // reset mid-frame with pending full
    ld_if.Load_valid = 1'b1;
    ld_if.Load_data  = 16'h4444;
    go(131);
    ld_if.Load_valid = 1'b0;
    check("mr_full", {15'h0000, ld_if.Load_ready}, 16'h0000);
    go(134);
    Reset_n = 1'b0;
    go(135);
    check("mr_sel",   {12'h000, Digit_sel}, 16'h0001);
    check("mr_seg",   {9'h000, Seg_out}, 16'h003F);
    check("mr_ready", {15'h0000, ld_if.Load_ready}, 16'h0001);
    check("mr_fd",    {15'h0000, Frame_done}, 16'h0000);
    Reset_n = 1'b1;
    t = 0;
    go(3);  check("mr_sel3", {12'h000, Digit_sel}, 16'h0001);
    go(4);  check("mr_sel4", {12'h000, Digit_sel}, 16'h0002);
            check("mr_d1",   {9'h000, Seg_out}, 16'h003F);
    go(16); check("mr_fd16", {15'h0000, Frame_done}, 16'h0001);
            check("mr_d0",   {9'h000, Seg_out}, 16'h003F);
    go(20); check("mr_d1b",  {9'h000, Seg_out}, 16'h003F);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
